// File: rtl/uart_store_replay_if.sv
// uart_store_replay_if: bundles the data, button, status and UART handshake signals of
// uart_store_replay.
//   master : UART core / button / supervisor side (drives rx, button, clear, mode, busy flag)
//   slave  : uart_store_replay side (drives transmit request, tx symbol and status)
interface uart_store_replay_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   logic              received;
   logic [DATA_W-1:0] rx_byte;
   logic              btn_pressed;
   logic              clear;
   logic [1:0]        case_mode;
   logic              is_transmitting;
   logic              transmit;
   logic [DATA_W-1:0] tx_byte;
   logic [ADDR_W:0]   count;
   logic              empty;
   logic              full;
   logic              overflow;
   logic              busy;

   modport master (
      output received, rx_byte, btn_pressed, clear, case_mode, is_transmitting,
      input  transmit, tx_byte, count, empty, full, overflow, busy
   );

   modport slave (
      input  received, rx_byte, btn_pressed, clear, case_mode, is_transmitting,
      output transmit, tx_byte, count, empty, full, overflow, busy
   );
endinterface

// File: rtl/uart_store_replay.sv
// uart_store_replay: stores received symbols (with optional ASCII case conversion) in a circular
// buffer and replays the whole buffer over the UART transmit handshake on each button press.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : uart_store_replay_if.slave (rx pulse/data, button, clear, case_mode, UART busy in;
//           transmit, tx_byte, count, empty, full, overflow, busy out)
module uart_store_replay #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned ADDR_W    = 8,
   parameter bit          OVERWRITE = 1'b0
) (
   input logic                clk,
   input logic                reset,
   uart_store_replay_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StLoad, StWait, StSend, StNext} state_e;

   localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_base_q, rd_base_d;
   logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   remain_q, remain_d;
   logic              overflow_q, overflow_d;
   logic              btn_prev_q;
   logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
   logic              mem_we;
   logic [DATA_W-1:0] wr_data;
   logic [7:0]        lo;
   logic              is_lower, is_upper;
   logic              full, btn_edge;

   // Case conversion touches only the low byte; wider symbols keep their upper bits.
   always_comb begin
      wr_data  = bus.rx_byte;
      lo       = bus.rx_byte[7:0];
      is_lower = (lo >= 8'h61) && (lo <= 8'h7a);
      is_upper = (lo >= 8'h41) && (lo <= 8'h5a);
      case (bus.case_mode)
         2'd1: if (is_lower) wr_data[7:0] = lo - 8'h20;
         2'd2: if (is_upper) wr_data[7:0] = lo + 8'h20;
         2'd3: begin
            if (is_lower)      wr_data[7:0] = lo - 8'h20;
            else if (is_upper) wr_data[7:0] = lo + 8'h20;
         end
         default: ;
      endcase
   end

   assign full     = (count_q == DepthCnt);
   assign btn_edge = bus.btn_pressed & ~btn_prev_q;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_base_d  = rd_base_q;
      rd_idx_d   = rd_idx_q;
      count_d    = count_q;
      remain_d   = remain_q;
      overflow_d = overflow_q;
      tx_byte_d  = tx_byte_q;
      mem_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            // clear wins over a same-cycle receive
            if (bus.clear) begin
               wr_ptr_d   = '0;
               rd_base_d  = '0;
               count_d    = '0;
               overflow_d = 1'b0;
            end else if (bus.received) begin
               if (!full) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                  count_d  = count_q + (ADDR_W + 1)'(1);
               end else if (OVERWRITE) begin
                  // Full ring: wr_ptr == rd_base, so the oldest entry is the one replaced.
                  mem_we     = 1'b1;
                  wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                  rd_base_d  = rd_base_q + ADDR_W'(1);
                  overflow_d = 1'b1;
               end else begin
                  overflow_d = 1'b1;
               end
            end
            if (btn_edge && (count_q != '0)) begin
               state_d  = StLoad;
               rd_idx_d = rd_base_q;
               remain_d = count_q;
            end
         end
         StLoad: begin
            tx_byte_d = mem[rd_idx_q];
            state_d   = StWait;
         end
         StWait: if (bus.is_transmitting)  state_d = StSend;
         StSend: if (!bus.is_transmitting) state_d = StNext;
         StNext: begin
            rd_idx_d = rd_idx_q + ADDR_W'(1);
            remain_d = remain_q - (ADDR_W + 1)'(1);
            state_d  = (remain_q == (ADDR_W + 1)'(1)) ? StIdle : StLoad;
         end
         default: state_d = StIdle;
      endcase

      // Symbols arriving during replay are lost.
      if (bus.received && (state_q != StIdle)) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_base_q  <= '0;
         rd_idx_q   <= '0;
         count_q    <= '0;
         remain_q   <= '0;
         overflow_q <= 1'b0;
         btn_prev_q <= 1'b0;
         tx_byte_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_base_q  <= rd_base_d;
         rd_idx_q   <= rd_idx_d;
         count_q    <= count_d;
         remain_q   <= remain_d;
         overflow_q <= overflow_d;
         btn_prev_q <= bus.btn_pressed;
         tx_byte_q  <= tx_byte_d;
      end
   end

   // Storage is not reset; a write is only ever enabled in IDLE with reset deasserted.
   always_ff @(posedge clk) begin
      if (reset && mem_we) mem[wr_ptr_q] <= wr_data;
   end

   assign bus.transmit = (state_q == StWait);
   assign bus.busy     = (state_q != StIdle);
   assign bus.tx_byte  = tx_byte_q;
   assign bus.count    = count_q;
   assign bus.empty    = (count_q == '0);
   assign bus.full     = full;
   assign bus.overflow = overflow_q;

endmodule

// File: doc/uart_store_replay.md
Name: uart_store_replay

Overview:
- Parametrised receive-store / replay controller between the UART core and the debounced push-button.
- Captures received bytes into a circular buffer, applying a run-time selectable case conversion.
- On each button press, replays the whole buffer in order over the UART transmit handshake. Replay is non-destructive.
- Adds configurable depth and width, overflow handling, clear, and status outputs.

Parameters:
- DATA_W, 8: symbol width. Must be >= 8. Case conversion acts on bits [7:0]; bits above 7 pass through unchanged.
- DEPTH, 256: buffer entries. Must be a power of two.
- ADDR_W, 8: log2(DEPTH).
- OVERWRITE, 0: full-buffer policy. 0 = drop the new byte; 1 = overwrite the oldest entry.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0.
- received  in  1  one-cycle pulse from the UART core: rx_byte valid.
- rx_byte  in  DATA_W  received symbol.
- btn_pressed  in  1  debounced button level.
- clear  in  1  one-cycle request to empty the buffer.
- case_mode  in  2  conversion mode. 0 = pass, 1 = to upper, 2 = to lower, 3 = toggle case.
- is_transmitting  in  1  UART core busy flag.
- transmit  out  1  request to the UART core to start sending tx_byte.
- tx_byte  out  DATA_W  symbol being sent (registered).
- count  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: a byte was dropped or an entry was overwritten.
- busy  out  1  replay in progress (state != IDLE).

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, wr_ptr=rd_base=0, count=0, overflow=0, tx_byte=0, transmit=0, busy=0, btn_prev=0. empty=1, full=0. Memory contents are not cleared.
- Case conversion, combinational on the write path:
  - upper: 0x61..0x7A minus 0x20.
  - lower: 0x41..0x5A plus 0x20.
  - toggle: applies whichever of the two ranges matches.
  - All other values are unchanged.
- Write, in IDLE when received==1 and clear==0. The converted byte is written to mem[wr_ptr] and wr_ptr increments modulo DEPTH. count is visible at N+1 for a pulse at N.
  - Not full: count+1.
  - Full, OVERWRITE=0: byte dropped; pointers and count unchanged; overflow<=1.
  - Full, OVERWRITE=1: write proceeds; rd_base increments modulo DEPTH; count stays DEPTH; overflow<=1.
- Received outside IDLE: byte dropped, overflow<=1, count unchanged.
- Clear:
  - In IDLE: wr_ptr=rd_base=0, count=0, overflow=0.
  - received in the same cycle as clear is discarded.
  - clear outside IDLE is ignored.
- Button: internal rising-edge detect, btn_pressed & ~btn_prev. A held button triggers exactly one replay.
- Replay FSM:
  - IDLE: edge && count!=0 -> LOAD, with rd_idx<=rd_base, remain<=count. Edge with count==0: stay in IDLE.
  - LOAD: tx_byte<=mem[rd_idx] -> WAIT.
  - WAIT: transmit=1; is_transmitting==1 -> SEND, else stay.
  - SEND: transmit=0; is_transmitting==0 -> NEXT, else stay.
  - NEXT: rd_idx<=rd_idx+1 (mod DEPTH), remain<=remain-1. If remain==1 -> IDLE, else -> LOAD.
- Latency: edge at cycle N -> LOAD at N+1 -> transmit=1 at N+2.
- transmit is a Moore output, high only in WAIT.
- Replay never changes wr_ptr, rd_base, or count. tx_byte holds its last value in IDLE.
- Button edges outside IDLE are ignored.
- Reset mid-replay: at the next edge, transmit=0 and busy=0. Any byte already handed to the UART core completes in the core; this block does not track it.
- Wrap-around: all pointer arithmetic is modulo DEPTH. count is ADDR_W+1 bits so that DEPTH is representable.

Test Plan:
- Basic replay: DEPTH=256, case_mode=1; receive 0x61 0x62 0x31 0x5A; pulse button.
  -> count=4.
  -> tx_byte sequence 0x41 0x42 0x31 0x5A, four transmit windows.
  -> Back to IDLE with busy=0 and count still 4.
  -> A second press replays the identical sequence.
- Modes: case_mode=3, receive 0x61 0x41 0x7B -> replay 0x41 0x61 0x7B. case_mode=2, receive 0x5A 0x7A -> replay 0x7A 0x7A.
- Full, drop policy: DEPTH=4, OVERWRITE=0; receive 0x01..0x06 -> full=1, overflow=1, count=4, replay 0x01 0x02 0x03 0x04.
- Full, overwrite policy: DEPTH=4, OVERWRITE=1, same stimulus -> replay 0x03 0x04 0x05 0x06 (pointer wrap exercised).
- Collisions: received pulse during SEND -> dropped, overflow=1, count unchanged. clear during WAIT -> ignored. clear in IDLE -> count=0, empty=1, overflow=0. received and clear in the same IDLE cycle -> count=0.
- Button edge cases: press with empty=1 -> transmit never asserts. Button held high for 1000 cycles -> exactly one replay.
- Reset mid-replay: reset=0 during SEND -> next cycle transmit=0, busy=0, count=0, empty=1.
